node_switch: RTL and testbench
==============================

# node_switch

Switch stage of the 5-port mesh router node: consumes the heads of the five per-port input FIFOs, computes the output port of each head flit by dimension-ordered XY routing, arbitrates round-robin per output, and moves winning flits through a 5x5 crossbar into one registered output slot per port. The block sits directly downstream of the per-port FIFOs (driving their `pop_req`) and upstream of the link converters (observing their `buffer_full`).

## Interface
- `NODE_X`, default 0, this node's X coordinate, range 0..15.
- `NODE_Y`, default 0, this node's Y coordinate, range 0..15.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  5  FIFO i has a valid head flit (FIFO `data_valid`).
- `in_data`  input  80  head flits; port i occupies bits [16*i+15:16*i].
- `in_pop`  output  5  pop to FIFO i; combinational, asserted in the cycle the head is taken.
- `out_valid`  output  5  output slot o holds a flit.
- `out_data`  output  80  output flits; same packing as `in_data`.
- `out_full`  input  5  downstream buffer o full; the flit leaves when `out_valid[o] & !out_full[o]`.
- `flit_count`  output  80  only with `NODE_SWITCH_FLIT_COUNT_EN`; per-output delivered-flit counters, same packing.

## Operation
- Port numbering, for inputs and outputs alike: 0 local, 1 +X, 2 -X, 3 +Y, 4 -Y.
- Flit format: [15:12] dest_x, [11:8] dest_y, [7:0] payload. The switch never modifies a flit.
- Route for a head flit:
  - dest_x > NODE_X gives port 1; dest_x < NODE_X gives 2.
  - Otherwise, dest_y > NODE_Y gives 3; dest_y < NODE_Y gives 4.
  - Otherwise 0.
  - U-turns are not filtered.
- Output slot o is free this cycle when `!out_valid[o] | !out_full[o]`.
- Arbitration for each output o, every cycle:
  - Requesters are inputs i with `in_valid[i]` and route(i)==o.
  - If slot o is free and at least one requester exists, grant exactly one requester.
  - Priority is round-robin, starting at pointer `rr[o]` (3 bits, 0..4) and scanning upward modulo 5.
- Each input routes to exactly one output, so it receives at most one grant. `in_pop[i]` equals that grant.
- On a grant to input i for output o:
  - Next cycle `out_data[o]` = in_data[i] and `out_valid[o]` = 1.
  - `rr[o]` becomes (i+1) mod 5.
- Pointer `rr[o]` is unchanged when there is no grant.
- Slot o behaviour:
  - Slot free and no grant: `out_valid[o]` goes to 0; `out_data[o]` holds its value.
  - Slot not free (valid and blocked): slot contents hold and no grant is issued for o.
  - Simultaneous drain and grant on the same edge: the new flit replaces the departing one, with no bubble.
- Outputs are independent: five outputs can each accept one flit in the same cycle.
- Reset:
  - `out_valid` = 0, `out_data` = 0, all `rr` = 0.
  - `in_pop` = 0 while `rst` is high, regardless of inputs.
  - Reset mid-operation discards flits held in output slots; FIFO contents are the FIFOs' concern.

## Timing
- Latency from head flit at the FIFO (`in_valid`, `in_pop` high) to `out_valid` is 1 cycle.
- Throughput is 1 flit per output per cycle.
- `in_pop` is combinational from `in_valid`, `in_data[15:8]` fields, `out_valid`, `out_full` and `rr`. There is no combinational path to `out_valid` or `out_data`.
- The FIFO must present its next head (or deassert `data_valid`) in the cycle after a pop.
- Backpressure: `out_full[o]` high holds slot o. Its requesters see `in_pop` = 0 and retain their heads, so no flit is lost or duplicated.

## Configuration
- `NODE_SWITCH_FLIT_COUNT_EN` defined:
  - Adds port `flit_count` and five 16-bit counters.
  - Counter o increments on each cycle with `out_valid[o] & !out_full[o]` and saturates at 0xFFFF.
  - Counters reset to 0.
- Undefined: the port and counters are absent. Switching behaviour is identical either way.

## Test plan
- NODE_X=2, NODE_Y=2. Single flits 0x3255, 0x1255, 0x2355, 0x2155, 0x22AA on input 0 in consecutive cycles, all `out_full` low.
  - `in_pop[0]` is high each cycle.
  - The flits appear on outputs 1, 2, 3, 4, 0 respectively, each one cycle after its pop.
- Inputs 0..4 all hold 0x2200 continuously (all route to output 0).
  - Grants rotate 0,1,2,3,4,0.
  - `out_valid[0]` stays high every cycle after the first.
- Flit on input 1 for output 3 with `out_full[3]` high for 4 cycles.
  - `out_data[3]` holds stable; `in_pop` for a second flit queued toward output 3 stays 0.
  - When `out_full[3]` falls, the held flit departs and the queued flit is loaded on the same edge.
- Five inputs each routed to a distinct output in the same cycle.
  - All five `in_pop` bits are high together; all five `out_valid` bits are high next cycle.
- `rst` asserted while `out_valid` = 5'b10110 and requests are pending.
  - Next cycle `out_valid` = 0 and `out_data` = 0.
  - `in_pop` = 0 during reset; arbitration restarts at input 0.
- With `NODE_SWITCH_FLIT_COUNT_EN` defined, drive 70000 flits to output 2.
  - The counter for output 2 reads 0xFFFF; the other counters read 0.

Source files
------------

// File: rtl/node_switch_if.sv
// Switch-side bundle of the router node: FIFO head/pop signals and output slot/backpressure signals.
// The switch connects through the slave modport; the FIFO/link-converter side uses master.
interface node_switch_if;
  logic [4:0]  in_valid;
  logic [79:0] in_data;
  logic [4:0]  in_pop;
  logic [4:0]  out_valid;
  logic [79:0] out_data;
  logic [4:0]  out_full;

  modport master (
    output in_valid, in_data, out_full,
    input  in_pop, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_full,
    output in_pop, out_valid, out_data
  );
endinterface

// File: rtl/node_switch.sv
// 5-port mesh router switch stage: XY routing, per-output round-robin arbitration, 5x5 crossbar
// into registered output slots. Optional macro NODE_SWITCH_FLIT_COUNT_EN adds per-output flit counters.
module node_switch #(
  parameter int NODE_X = 0,
  parameter int NODE_Y = 0
) (
  input  logic         clk,
  input  logic         rst,
  node_switch_if.slave sw
`ifdef NODE_SWITCH_FLIT_COUNT_EN
  ,
  output logic [79:0]  flit_count
`endif
);

  localparam logic [3:0] NodeXL = 4'(NODE_X);
  localparam logic [3:0] NodeYL = 4'(NODE_Y);

  logic [4:0]       out_valid_q, out_valid_d;
  logic [4:0][15:0] out_data_q, out_data_d;
  logic [4:0][2:0]  rr_q, rr_d;
  logic [4:0][2:0]  route;
  logic [4:0][2:0]  winner;
  logic [4:0]       slot_free;
  logic [4:0]       has_grant;
  logic [4:0]       pop;

  always_comb begin
    route = '0;
    for (int i = 0; i < 5; i++) begin
      if (sw.in_data[16*i+12 +: 4] > NodeXL)      route[i] = 3'd1;
      else if (sw.in_data[16*i+12 +: 4] < NodeXL) route[i] = 3'd2;
      else if (sw.in_data[16*i+8 +: 4] > NodeYL)  route[i] = 3'd3;
      else if (sw.in_data[16*i+8 +: 4] < NodeYL)  route[i] = 3'd4;
      else                                        route[i] = 3'd0;
    end
  end

  // Scan requesters starting at rr[o], wrapping modulo 5; first hit wins.
  always_comb begin : arbitrate
    logic [3:0] idx;
    logic [2:0] cand;
    idx       = '0;
    cand      = '0;
    slot_free = '0;
    has_grant = '0;
    winner    = '0;
    for (int o = 0; o < 5; o++) begin
      slot_free[o] = !out_valid_q[o] || !sw.out_full[o];
      for (int k = 0; k < 5; k++) begin
        idx = {1'b0, rr_q[o]} + 4'(k);
        if (idx >= 4'd5) idx = idx - 4'd5;
        cand = idx[2:0];
        if (slot_free[o] && !has_grant[o] && sw.in_valid[cand] && (route[cand] == 3'(o))) begin
          has_grant[o] = 1'b1;
          winner[o]    = cand;
        end
      end
    end
  end

  // A grant loads the slot (replacing a departing flit on the same edge); a free idle slot empties.
  always_comb begin
    pop         = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rr_d        = rr_q;
    for (int o = 0; o < 5; o++) begin
      if (has_grant[o]) begin
        pop[winner[o]] = 1'b1;
        out_valid_d[o] = 1'b1;
        out_data_d[o]  = sw.in_data[{winner[o], 4'b0000} +: 16];
        rr_d[o]        = (winner[o] == 3'd4) ? 3'd0 : winner[o] + 3'd1;
      end else if (slot_free[o]) begin
        out_valid_d[o] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
      rr_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rr_q        <= rr_d;
    end
  end

  assign sw.in_pop    = rst ? 5'b00000 : pop;
  assign sw.out_valid = out_valid_q;
  assign sw.out_data  = out_data_q;

`ifdef NODE_SWITCH_FLIT_COUNT_EN
  logic [4:0][15:0] cnt_q, cnt_d;

  // Count departures, saturating at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    for (int o = 0; o < 5; o++) begin
      if (out_valid_q[o] && !sw.out_full[o] && (cnt_q[o] != 16'hFFFF)) begin
        cnt_d[o] = cnt_q[o] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign flit_count = cnt_q;
`endif

endmodule

// File: tb/tb_node_switch.sv
// Scoreboard bench for node_switch (NODE_X=2, NODE_Y=2): FIFO-queue stimulus, reference model
// predicts pops and output flits, a monitor checks each departing flit in order.
`timescale 1ns/1ps
module tb_node_switch;
  localparam int NX = 2;
  localparam int NY = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  node_switch_if sw_if ();

`ifdef NODE_SWITCH_FLIT_COUNT_EN
  logic [79:0] flit_count;
  node_switch #(.NODE_X(NX), .NODE_Y(NY)) dut (
    .clk(clk), .rst(rst), .sw(sw_if.slave), .flit_count(flit_count)
  );
`else
  node_switch #(.NODE_X(NX), .NODE_Y(NY)) dut (
    .clk(clk), .rst(rst), .sw(sw_if.slave)
  );
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] fifo_q [5][$];
  logic [15:0] exp_q  [5][$];
  logic [4:0]  model_valid = '0;
  int          model_rr  [5];
  int          model_cnt [5];
  logic [4:0]  drv_valid = '0;
  logic [79:0] drv_data  = '0;
  logic [4:0]  drv_full  = '0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int route_ref(input logic [15:0] f);
    int dx, dy;
    dx = int'(f[15:12]);
    dy = int'(f[11:8]);
    if (dx > NX) return 1;
    if (dx < NX) return 2;
    if (dy > NY) return 3;
    if (dy < NY) return 4;
    return 0;
  endfunction

  function automatic bit busy();
    for (int i = 0; i < 5; i++) if (fifo_q[i].size() != 0) return 1'b1;
    return model_valid != 5'b0;
  endfunction

  task automatic drive();
    sw_if.in_valid = drv_valid;
    sw_if.in_data  = drv_data;
    sw_if.out_full = drv_full;
  endtask

  // Reference: each output picks the requester closest to its pointer going upward mod 5.
  task automatic checkOutput();
    logic [4:0] exp_pop, nv;
    logic free;
    int best, bestd, d;
    exp_pop = '0;
    nv = model_valid;
    check("out_valid", 80'(sw_if.out_valid), 80'(model_valid));
    for (int o = 0; o < 5; o++) begin
      free  = !model_valid[o] || !drv_full[o];
      best  = -1;
      bestd = 5;
      if (free) begin
        for (int i = 0; i < 5; i++) begin
          if (drv_valid[i] && route_ref(drv_data[16*i +: 16]) == o) begin
            d = (i - model_rr[o] + 5) % 5;
            if (d < bestd) begin
              bestd = d;
              best  = i;
            end
          end
        end
      end
      if (best >= 0) begin
        exp_pop[best] = 1'b1;
        exp_q[o].push_back(drv_data[16*best +: 16]);
        nv[o] = 1'b1;
        model_rr[o] = (best + 1) % 5;
        void'(fifo_q[best].pop_front());
      end else if (free) begin
        nv[o] = 1'b0;
      end
    end
    check("in_pop", 80'(sw_if.in_pop), 80'(exp_pop));
    model_valid = nv;
  endtask

  task automatic applyStimulus(input logic [4:0] full);
    @(posedge clk); #1;
    drv_data = '0;
    for (int i = 0; i < 5; i++) begin
      drv_valid[i] = (fifo_q[i].size() != 0);
      if (drv_valid[i]) drv_data[16*i +: 16] = fifo_q[i][0];
    end
    drv_full = full;
    drive();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst       = 1'b1;
    drv_valid = 5'b11111;
    drv_data  = {5{16'h2200}};
    drv_full  = 5'($urandom);
    drive();
    @(negedge clk);
    check("in_pop_during_reset", 80'(sw_if.in_pop), 80'(0));
    @(posedge clk); #1;
    check("out_valid_after_reset", 80'(sw_if.out_valid), 80'(0));
    check("out_data_after_reset", sw_if.out_data, 80'(0));
    rst       = 1'b0;
    drv_valid = '0;
    drive();
    for (int o = 0; o < 5; o++) begin
      exp_q[o].delete();
      model_rr[o]  = 0;
      model_cnt[o] = 0;
    end
    model_valid = '0;
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < 5; i++) fifo_q[i].delete();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy() && n < 300) begin
      applyStimulus(5'b00000);
      n++;
    end
    if (busy()) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout got busy expected idle after %0d cycles", n);
    end
  endtask

  // Monitor: every flit that leaves a slot must be the oldest expected flit for that output.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int o = 0; o < 5; o++) begin
          if (sw_if.out_valid[o] && !sw_if.out_full[o]) begin
            if (exp_q[o].size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL unexpected_flit out %0d got %h expected none", o, sw_if.out_data[16*o +: 16]);
            end else begin
              e = exp_q[o].pop_front();
              check($sformatf("out_data[%0d]", o), 80'(sw_if.out_data[16*o +: 16]), 80'(e));
            end
            if (model_cnt[o] < 65535) model_cnt[o]++;
          end
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    drv_valid = '0;
    drv_full  = '0;
    drive();
    for (int o = 0; o < 5; o++) begin
      model_rr[o]  = 0;
      model_cnt[o] = 0;
    end
    do_reset();

    $display("[TB] single-input routing sweep");
    fifo_q[0] = '{16'h3255, 16'h1255, 16'h2355, 16'h2155, 16'h22AA};
    drain();

    $display("[TB] all inputs contend for output 0");
    for (int i = 0; i < 5; i++) for (int k = 0; k < 3; k++) fifo_q[i].push_back(16'h2200 | 16'(i*16 + k));
    drain();

    $display("[TB] backpressure on output 3");
    fifo_q[1].push_back(16'h2355);
    applyStimulus(5'b00000);
    fifo_q[2].push_back(16'h2366);
    for (int k = 0; k < 4; k++) applyStimulus(5'b01000);
    applyStimulus(5'b00000);
    drain();

    $display("[TB] five inputs to five distinct outputs");
    fifo_q[0].push_back(16'h3201);
    fifo_q[1].push_back(16'h1202);
    fifo_q[2].push_back(16'h2303);
    fifo_q[3].push_back(16'h2104);
    fifo_q[4].push_back(16'h2205);
    applyStimulus(5'b00000);
    applyStimulus(5'b00000);
    drain();

    $display("[TB] reset with held slots and pending requests");
    fifo_q[1].push_back(16'h3211);
    fifo_q[2].push_back(16'h1222);
    fifo_q[3].push_back(16'h2144);
    applyStimulus(5'b00000);
    fifo_q[0].push_back(16'h3299);
    applyStimulus(5'b10110);
    applyStimulus(5'b10110);
    clear_fifos();
    do_reset();
    for (int i = 0; i < 5; i++) fifo_q[i].push_back(16'h2200 | 16'(8'hA0 + i));
    drain();

    $display("[TB] randomized traffic");
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 5; i++) begin
        if (fifo_q[i].size() < 4 && $urandom_range(0, 99) < 45) begin
          fifo_q[i].push_back({4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)), 8'($urandom)});
        end
      end
      applyStimulus(5'($urandom & $urandom));
    end
    drain();

`ifdef NODE_SWITCH_FLIT_COUNT_EN
    $display("[TB] counter saturation on output 2");
    do_reset();
    for (int k = 0; k < 70000; k++) fifo_q[1].push_back(16'h1200 | 16'(k[7:0]));
    while (fifo_q[1].size() != 0) applyStimulus(5'b00000);
    drain();
    @(posedge clk); #1;
    check("flit_count[2]_saturated", 80'(flit_count[32 +: 16]), 80'(16'hFFFF));
    for (int o = 0; o < 5; o++) begin
      check($sformatf("flit_count[%0d]", o), 80'(flit_count[16*o +: 16]), 80'(model_cnt[o]));
    end
`endif

    @(posedge clk); #1;
    for (int o = 0; o < 5; o++) begin
      check($sformatf("scoreboard_empty[%0d]", o), 80'(exp_q[o].size()), 80'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
